serial_pattern_gen: RTL and testbench

Upstream stimulus stage for the lab 6 sequence detector. It captures a pattern of up to WIDTH bits from the switches and replays it one bit per clock on a registered serial output `w`, which drives the detector's `w` input directly. It supports single-shot or continuous repeat, abort, and a per-pass done pulse. A whole test sequence can then be presented to the FSM at clock rate instead of being toggled by hand.

---
 rtl/serial_pattern_gen.sv | 136 +++++++++++++
 tb/tb_serial_pattern_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// Serial stimulus generator: captures a pattern from the switches and replays it
// LSB first on a registered bit stream, with optional back-to-back repeat.
module serial_pattern_gen #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Pattern,
  input  logic [3:0]       Length,
  input  logic             Start,
  input  logic             Repeat,
  input  logic             Stop,
  output logic             w,
  output logic             w_valid,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       BitIndex
);

  typedef enum logic [1:0] {
    IDLE,
    READY,
    SHIFT,
    FINISH
  } state_t;

  localparam logic [3:0] WIDTH_L = 4'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] held_pat, held_pat_nxt;
  logic [3:0]       held_len, held_len_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [3:0]       idx_nxt;
  logic             vld_nxt;
  logic             done_nxt;
  logic             w_nxt;
  logic             busy_nxt;
  logic             last_bit;

  // Out-of-range lengths saturate to the full register width.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0 || len > WIDTH_L) begin
      return WIDTH_L;
    end
    return len;
  endfunction

  assign last_bit = (BitIndex == held_len - 4'd1);

  always_comb begin
    state_nxt    = state;
    held_pat_nxt = held_pat;
    held_len_nxt = held_len;
    sreg_nxt     = sreg;
    idx_nxt      = 4'd0;
    vld_nxt      = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (Load) begin
          held_pat_nxt = Pattern;
          held_len_nxt = clamp_len(Length);
          state_nxt    = READY;
        end
      end

      READY: begin
        if (Load) begin
          held_pat_nxt = Pattern;
          held_len_nxt = clamp_len(Length);
        end else if (Start) begin
          sreg_nxt  = held_pat;
          vld_nxt   = 1'b1;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        // Abort wins over the end-of-pass decision on the same edge.
        if (Stop) begin
          state_nxt = READY;
        end else if (last_bit) begin
          done_nxt = 1'b1;
          if (Repeat) begin
            sreg_nxt = held_pat;
            vld_nxt  = 1'b1;
          end else begin
            state_nxt = FINISH;
          end
        end else begin
          sreg_nxt = sreg >> 1;
          idx_nxt  = BitIndex + 4'd1;
          vld_nxt  = 1'b1;
        end
      end

      FINISH: begin
        state_nxt = READY;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    w_nxt    = vld_nxt & sreg_nxt[0];
    busy_nxt = (state_nxt == SHIFT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      held_pat <= '0;
      held_len <= 4'd0;
      sreg     <= '0;
      BitIndex <= 4'd0;
      w        <= 1'b0;
      w_valid  <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      held_pat <= held_pat_nxt;
      held_len <= held_len_nxt;
      sreg     <= sreg_nxt;
      BitIndex <= idx_nxt;
      w        <= w_nxt;
      w_valid  <= vld_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed scenarios plus random traffic, checked
// each cycle against a bit-position reference model.
module tb_serial_pattern_gen;

  logic       Clock;
  logic       Reset;
  logic       Load;
  logic [7:0] Pattern;
  logic [3:0] Length;
  logic       Start;
  logic       Repeat;
  logic       Stop;
  logic       w;
  logic       w_valid;
  logic       Busy;
  logic       Done;
  logic [3:0] BitIndex;

  serial_pattern_gen #(.WIDTH(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (Load),
    .Pattern  (Pattern),
    .Length   (Length),
    .Start    (Start),
    .Repeat   (Repeat),
    .Stop     (Stop),
    .w        (w),
    .w_valid  (w_valid),
    .Busy     (Busy),
    .Done     (Done),
    .BitIndex (BitIndex)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: mode 0=nothing loaded, 1=pattern held, 2=sending, 3=pass finished
  int         m_mode = 0;
  logic [7:0] m_pat  = 8'h00;
  int         m_len  = 0;
  int         m_pos  = 0;
  logic       m_done = 1'b0;

  task automatic model_step(input logic r, ld, input logic [7:0] pt, input logic [3:0] ln,
                            input logic st, rp, sp);
    m_done = 1'b0;
    if (r) begin
      m_mode = 0;
      m_pat  = 8'h00;
      m_len  = 0;
      m_pos  = 0;
    end else if (m_mode == 0 || m_mode == 1) begin
      if (ld) begin
        m_pat  = pt;
        m_len  = (ln == 0 || ln > 8) ? 8 : int'(ln);
        m_mode = 1;
      end else if (m_mode == 1 && st) begin
        m_mode = 2;
        m_pos  = 0;
      end
    end else if (m_mode == 2) begin
      if (sp) begin
        m_mode = 1;
        m_pos  = 0;
      end else if (m_pos == m_len - 1) begin
        m_done = 1'b1;
        m_pos  = 0;
        if (!rp) m_mode = 3;
      end else begin
        m_pos = m_pos + 1;
      end
    end else begin
      m_mode = 1;
    end
  endtask

  task automatic cyc(input logic r, ld, input logic [7:0] pt, input logic [3:0] ln,
                     input logic st, rp, sp);
    logic sending;
    Reset   = r;
    Load    = ld;
    Pattern = pt;
    Length  = ln;
    Start   = st;
    Repeat  = rp;
    Stop    = sp;
    @(posedge Clock);
    model_step(r, ld, pt, ln, st, rp, sp);
    @(negedge Clock);
    sending = (m_mode == 2);
    check("w_valid", 32'(w_valid), 32'(sending));
    check("w", 32'(w), sending ? 32'(m_pat[m_pos]) : 32'd0);
    check("Busy", 32'(Busy), 32'(sending));
    check("Done", 32'(Done), 32'(m_done));
    check("BitIndex", 32'(BitIndex), sending ? 32'(m_pos) : 32'd0);
  endtask

  task automatic idle_cyc(input logic rp);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, rp, 1'b0);
  endtask

  logic [7:0] seq;
  int         cnt;

  initial begin
    Reset = 1'b1; Load = 1'b0; Pattern = 8'h00; Length = 4'd0;
    Start = 1'b0; Repeat = 1'b0; Stop = 1'b0;

    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(w_valid), 32'd0);
    idle_cyc(1'b0);

    // Single shot of 1110_0001, length 8
    cyc(1'b0, 1'b1, 8'b1110_0001, 4'd8, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    seq[0] = w;
    for (int i = 1; i < 8; i++) begin
      idle_cyc(1'b0);
      seq[i] = w;
    end
    check("ss_seq", 32'(seq), 32'h0000_00E1);
    idle_cyc(1'b0);
    check("ss_done", 32'(Done), 32'd1);
    idle_cyc(1'b0);
    idle_cyc(1'b0);

    // Continuous repeat of 0000_1111 length 4, then drop Repeat
    cyc(1'b0, 1'b1, 8'b0000_1111, 4'd4, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0);
    cnt = int'(w_valid);
    for (int i = 1; i < 12; i++) begin
      idle_cyc(1'b1);
      cnt += int'(w_valid);
    end
    check("rep_valid_cnt", 32'(cnt), 32'd12);
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    for (int i = 0; i < 5; i++) idle_cyc(1'b0);

    // Reset mid-pass, then Start without Load must produce nothing
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_cyc(1'b0);
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    check("midrst_idx", 32'(BitIndex), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    check("midrst_nostart", 32'(w_valid), 32'd0);

    // Stop at bit 3, Load ignored during SHIFT, restart replays original
    cyc(1'b0, 1'b1, 8'b1010_0101, 4'd8, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'b0101_1010, 4'd8, 1'b0, 1'b0, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    check("stop_at_idx", 32'(BitIndex), 32'd3);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    check("stop_valid", 32'(w_valid), 32'd0);
    check("stop_nodone", 32'(Done), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    seq[0] = w;
    for (int i = 1; i < 4; i++) begin
      idle_cyc(1'b0);
      seq[i] = w;
    end
    check("restart_orig", 32'(seq[3:0]), 32'h5);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);

    // Clamp: Length 0 and Length 12 both give 8 bits
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 8'h3C, (k == 0) ? 4'd0 : 4'd12, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      cnt = int'(w_valid);
      for (int i = 1; i < 12; i++) begin
        idle_cyc(1'b0);
        cnt += int'(w_valid);
      end
      check("clamp_cnt", 32'(cnt), 32'd8);
    end

    // Load and Start together: Load wins
    cyc(1'b0, 1'b1, 8'b0000_0010, 4'd3, 1'b1, 1'b0, 1'b0);
    check("ls_nobusy", 32'(Busy), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    check("ls_newbit0", 32'(w), 32'd0);
    idle_cyc(1'b0);
    check("ls_newbit1", 32'(w), 32'd1);
    for (int i = 0; i < 3; i++) idle_cyc(1'b0);

    // Reset coinciding with the final-bit edge suppresses Done
    cyc(1'b0, 1'b1, 8'b0000_1111, 4'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_cyc(1'b0);
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    check("rstlast_nodone", 32'(Done), 32'd0);
    idle_cyc(1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
          8'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 35),
          ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
